riscv_branch_unit: RTL and testbench

Parametrised, registered branch-resolution unit for the RISC-V execute stage. It evaluates conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR. It computes the redirect target and link value, and flags mispredictions against the front-end's prediction. It also owns a small table of 2-bit saturating counters (BHT) that the fetch stage reads and that is trained on every retired conditional branch.

---
 rtl/riscv_branch_unit.sv | 175 +++++++++++++++++
 tb/tb_riscv_branch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_branch_unit.sv
// Execute-stage branch resolution for RISC-V: evaluates BEQ..BGEU, JAL and JALR into a
// one-entry registered result, and owns the 2-bit saturating-counter table read by fetch.
module riscv_branch_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_kind,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_pred_taken,
   input  logic [XLEN-1:0] in_pred_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_target,
   output logic [XLEN-1:0] out_link,
   output logic            out_mispredict,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_taken
);

   localparam int IDX = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

   typedef enum logic [1:0] {
      KIND_BRANCH = 2'd0,
      KIND_JAL    = 2'd1,
      KIND_JALR   = 2'd2,
      KIND_NOP    = 2'd3
   } kind_e;

   localparam logic [1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [1:0] CTR_MAX     = 2'b11;
   localparam logic [1:0] CTR_MIN     = 2'b00;

   logic            w_eq;
   logic            w_ltu;
   logic            w_lt;
   logic            w_cond;
   logic            w_taken;
   logic [XLEN-1:0] w_pc_plus_imm;
   logic [XLEN-1:0] w_rs1_plus_imm;
   logic [XLEN-1:0] w_jump_target;
   logic [XLEN-1:0] w_link;
   logic [XLEN-1:0] w_target;
   logic            w_mispredict;
   logic            w_accept;
   logic            w_train;
   logic [IDX-1:0]  w_in_idx;
   logic [IDX-1:0]  w_lookup_idx;
   logic            w_unused_pc_bits;
   logic [1:0]      w_ctr [BHT_ENTRIES];

   logic            r_valid;
   logic            r_taken;
   logic [XLEN-1:0] r_target;
   logic [XLEN-1:0] r_link;
   logic            r_mispredict;
   logic            r_is_branch;
   logic [IDX-1:0]  r_idx;

   // Signed less-than reuses the unsigned comparator: differing sign bits decide on their own.
   assign w_eq  = (in_rs1 == in_rs2);
   assign w_ltu = (in_rs1 < in_rs2);
   assign w_lt  = (in_rs1[XLEN-1] != in_rs2[XLEN-1]) ? in_rs1[XLEN-1] : w_ltu;

   always_comb begin
      w_cond = 1'b0;
      case (in_funct3)
         3'd0:    w_cond = w_eq;
         3'd1:    w_cond = !w_eq;
         3'd4:    w_cond = w_lt;
         3'd5:    w_cond = !w_lt;
         3'd6:    w_cond = w_ltu;
         3'd7:    w_cond = !w_ltu;
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (kind_e'(in_kind))
         KIND_BRANCH: w_taken = w_cond;
         KIND_JAL:    w_taken = 1'b1;
         KIND_JALR:   w_taken = 1'b1;
         default:     w_taken = 1'b0;
      endcase
   end

   assign w_pc_plus_imm  = in_pc + in_imm;
   assign w_rs1_plus_imm = in_rs1 + in_imm;
   assign w_link         = in_pc + XLEN'(4);
   assign w_jump_target  = (in_kind == KIND_JALR) ? {w_rs1_plus_imm[XLEN-1:1], 1'b0}
                                                  : w_pc_plus_imm;
   assign w_target       = w_taken ? w_jump_target : w_link;
   assign w_mispredict   = (in_kind != KIND_NOP) &&
                           ((w_taken != in_pred_taken) ||
                            (w_taken && (w_target != in_pred_target)));

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready && !flush;
   assign w_train  = r_valid && out_ready && !flush && r_is_branch;

   assign w_in_idx         = in_pc[IDX+1:2];
   assign w_lookup_idx     = pred_pc[IDX+1:2];
   assign w_unused_pc_bits = ^{pred_pc[XLEN-1:IDX+2], pred_pc[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // Payload only moves on an accept, so it holds still under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken      <= 1'b0;
         r_target     <= '0;
         r_link       <= '0;
         r_mispredict <= 1'b0;
         r_is_branch  <= 1'b0;
         r_idx        <= '0;
      end else if (w_accept) begin
         r_taken      <= w_taken;
         r_target     <= w_target;
         r_link       <= w_link;
         r_mispredict <= w_mispredict;
         r_is_branch  <= (in_kind == KIND_BRANCH);
         r_idx        <= w_in_idx;
      end
   end

   generate
      for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
         logic [1:0] r_ctr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_ctr <= CTR_WEAK_NT;
            end else if (w_train && (r_idx == IDX'(gi))) begin
               if (r_taken && (r_ctr != CTR_MAX)) begin
                  r_ctr <= r_ctr + 2'd1;
               end else if (!r_taken && (r_ctr != CTR_MIN)) begin
                  r_ctr <= r_ctr - 2'd1;
               end
            end
         end

         assign w_ctr[gi] = r_ctr;
      end
   endgenerate

   // Lookup reads the registered counters, so a same-cycle update shows up one cycle later.
   assign pred_taken = w_ctr[w_lookup_idx][1];

   assign out_valid      = r_valid;
   assign out_taken      = r_taken;
   assign out_target     = r_target;
   assign out_link       = r_link;
   assign out_mispredict = r_mispredict;

endmodule

// File: tb/tb_riscv_branch_unit.sv
// Bench for riscv_branch_unit: directed corner cases plus random traffic against a
// cycle-level reference model of the result register and the counter table.
module tb_riscv_branch_unit;

   localparam int XLEN = 32;
   localparam int N    = 16;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_kind;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_pc;
   logic [XLEN-1:0] in_rs1;
   logic [XLEN-1:0] in_rs2;
   logic [XLEN-1:0] in_imm;
   logic            in_pred_taken;
   logic [XLEN-1:0] in_pred_target;
   logic            out_valid;
   logic            out_ready;
   logic            out_taken;
   logic [XLEN-1:0] out_target;
   logic [XLEN-1:0] out_link;
   logic            out_mispredict;
   logic [XLEN-1:0] pred_pc;
   logic            pred_taken;

   riscv_branch_unit #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_funct3(in_funct3),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_target(out_target), .out_link(out_link), .out_mispredict(out_mispredict),
      .pred_pc(pred_pc), .pred_taken(pred_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic        mis;
   } res_t;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   m_valid;
   res_t m_res;
   logic [1:0]  m_kind;
   logic [31:0] m_pc;
   int   m_bht [N];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic res_t ref_model(input logic [1:0] kind, input logic [2:0] f3,
                                      input logic [31:0] pc, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] imm,
                                      input logic pt, input logic [31:0] ptgt);
      res_t r;
      logic t;
      t = 1'b0;
      if (kind == 2'd1 || kind == 2'd2) begin
         t = 1'b1;
      end else if (kind == 2'd0) begin
         case (f3)
            3'd0:    t = (rs1 == rs2);
            3'd1:    t = (rs1 != rs2);
            3'd4:    t = ($signed(rs1) <  $signed(rs2));
            3'd5:    t = ($signed(rs1) >= $signed(rs2));
            3'd6:    t = (rs1 <  rs2);
            3'd7:    t = (rs1 >= rs2);
            default: t = 1'b0;
         endcase
      end
      r.taken = t;
      r.link  = pc + 32'd4;
      if (!t)              r.target = pc + 32'd4;
      else if (kind == 2)  r.target = (rs1 + imm) & 32'hFFFF_FFFE;
      else                 r.target = pc + imm;
      r.mis = (kind != 2'd3) && ((t != pt) || (t && (r.target != ptgt)));
      return r;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_res   = '0;
      m_kind  = 2'd3;
      m_pc    = '0;
      for (int i = 0; i < N; i++) m_bht[i] = 1;
   endtask

   task automatic drive_idle();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_kind = 2'd3; in_funct3 = 3'd0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
      in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0;
   endtask

   task automatic set_req(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                          input logic pt, input logic [31:0] ptgt);
      in_valid = 1'b1; in_kind = kind; in_funct3 = f3; in_pc = pc;
      in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
   endtask

   task automatic check_outputs();
      check_eq("out_valid", out_valid, m_valid);
      if (m_valid) begin
         check_eq("out_taken", out_taken, m_res.taken);
         check_eq("out_target", out_target, m_res.target);
         check_eq("out_link", out_link, m_res.link);
         check_eq("out_mispredict", out_mispredict, m_res.mis);
      end
   endtask

   task automatic pred_check(input string tag, input logic [31:0] pc, input logic exp);
      pred_pc = pc;
      #1;
      check_eq(tag, pred_taken, exp);
   endtask

   // Called just after a falling edge with inputs set; advances one clock.
   task automatic step();
      res_t r;
      bit   acc;
      bit   trn;
      int   ti;
      #1;
      check_eq("in_ready", in_ready, !m_valid || out_ready);
      check_eq("pred_taken", pred_taken, m_bht[pred_pc[5:2]] >= 2);
      acc = in_valid && (!m_valid || out_ready) && !flush;
      trn = m_valid && out_ready && !flush && (m_kind == 2'd0);
      r = ref_model(in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, in_pred_taken, in_pred_target);
      @(posedge clk);
      if (trn) begin
         ti = int'(m_pc[5:2]);
         if (m_res.taken) m_bht[ti] = (m_bht[ti] == 3) ? 3 : m_bht[ti] + 1;
         else             m_bht[ti] = (m_bht[ti] == 0) ? 0 : m_bht[ti] - 1;
      end
      if (flush) m_valid = 1'b0;
      else if (acc) begin
         m_valid = 1'b1; m_res = r; m_kind = in_kind; m_pc = in_pc;
      end else if (out_ready) m_valid = 1'b0;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive_idle();
      pred_pc = '0;
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rs1_v;
      logic [31:0] pc_v;
      res_t        r;

      do_reset();

      // Reset state
      #1;
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_out_taken", out_taken, 1'b0);
      check_eq("rst_out_target", out_target, 32'h0);
      check_eq("rst_out_link", out_link, 32'h0);
      check_eq("rst_out_mispredict", out_mispredict, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < N; i++) pred_check("rst_pred", i * 4, 1'b0);
      @(negedge clk);

      // Signed vs unsigned compare, reserved funct3, JALR
      set_req(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0, 32'h0);
      step();
      check_eq("blt_signed_taken", out_taken, 1'b1);
      set_req(2'd0, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0, 32'h0);
      step();
      check_eq("bltu_taken", out_taken, 1'b0);
      set_req(2'd0, 3'd2, 32'h200, 32'h5, 32'h5, 32'h10, 1'b0, 32'h0);
      step();
      check_eq("f3_2_taken", out_taken, 1'b0);
      check_eq("f3_2_target", out_target, 32'h204);
      set_req(2'd2, 3'd0, 32'h100, 32'h2001, 32'h0, 32'h4, 1'b1, 32'h2004);
      step();
      check_eq("jalr_target", out_target, 32'h2004);
      check_eq("jalr_link", out_link, 32'h104);
      check_eq("jalr_mis_hit", out_mispredict, 1'b0);
      set_req(2'd2, 3'd0, 32'h100, 32'h2001, 32'h0, 32'h4, 1'b1, 32'h2000);
      step();
      check_eq("jalr_mis_wrong", out_mispredict, 1'b1);
      drive_idle();
      step();

      // BHT training and aliasing
      do_reset();
      pred_pc = 32'h40;
      set_req(2'd0, 3'd0, 32'h40, 32'h5, 32'h5, 32'h8, 1'b0, 32'h0);
      step();
      pred_check("bht_before_train", 32'h40, 1'b0);
      step();
      pred_check("bht_after_first", 32'h40, 1'b1);
      step();
      drive_idle();
      pred_pc = 32'h40;
      step();
      step();
      pred_check("bht_saturated", 32'h40, 1'b1);
      set_req(2'd0, 3'd1, 32'h80, 32'h7, 32'h7, 32'h8, 1'b1, 32'h88);
      step();
      step();
      drive_idle();
      step();
      pred_check("bht_alias_80", 32'h80, 1'b0);
      pred_check("bht_back_to_1", 32'h40, 1'b0);
      set_req(2'd0, 3'd0, 32'h40, 32'h1, 32'h1, 32'h8, 1'b0, 32'h0);
      step();
      drive_idle();
      pred_pc = 32'h80;
      step();
      pred_check("bht_alias_rise", 32'h80, 1'b1);

      // Backpressure then back-to-back drain
      drive_idle();
      out_ready = 1'b0;
      set_req(2'd1, 3'd0, 32'h300, 32'h0, 32'h0, 32'h40, 1'b1, 32'h340);
      step();
      set_req(2'd1, 3'd0, 32'h500, 32'h0, 32'h0, 32'h20, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("bp_in_ready", in_ready, 1'b0);
         check_eq("bp_hold_target", out_target, 32'h340);
      end
      out_ready = 1'b1;
      step();
      check_eq("bp_release_target", out_target, 32'h520);
      for (int k = 0; k < 4; k++) begin
         set_req(2'd0, 3'd0, 32'h400 + k * 16, k, k, 32'h100, 1'b1, 32'h500 + k * 16);
         step();
         check_eq("b2b_target", out_target, 32'h500 + k * 16);
      end
      drive_idle();
      step();

      // Flush with a pending handshake and an incoming request
      do_reset();
      pred_pc = 32'h40;
      out_ready = 1'b0;
      set_req(2'd0, 3'd0, 32'h40, 32'h3, 32'h3, 32'h8, 1'b0, 32'h0);
      step();
      out_ready = 1'b1;
      flush = 1'b1;
      set_req(2'd1, 3'd0, 32'h44, 32'h0, 32'h0, 32'h8, 1'b1, 32'h4C);
      step();
      check_eq("flush_clears_valid", out_valid, 1'b0);
      drive_idle();
      pred_pc = 32'h40;
      step();
      check_eq("flush_no_accept", out_valid, 1'b0);
      pred_check("flush_no_train", 32'h40, 1'b0);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         in_kind   = 2'($urandom_range(0, 3));
         in_funct3 = 3'($urandom_range(0, 7));
         pc_v      = $urandom();
         in_pc     = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 63)) << 2) : pc_v;
         rs1_v     = $urandom();
         if ($urandom_range(0, 3) == 0) rs1_v = rs1_v ^ 32'h8000_0000;
         in_rs1    = rs1_v;
         in_rs2    = ($urandom_range(0, 3) == 0) ? rs1_v : $urandom();
         in_imm    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($signed(12'($urandom())));
         in_pred_taken = 1'($urandom_range(0, 1));
         r = ref_model(in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, 1'b0, 32'h0);
         in_pred_target = ($urandom_range(0, 1) == 0) ? r.target : $urandom();
         pred_pc   = 32'($urandom_range(0, 63)) << 2;
         step();
      end

      // Asynchronous reset while a result is held
      drive_idle();
      out_ready = 1'b0;
      set_req(2'd1, 3'd0, 32'h600, 32'h0, 32'h0, 32'h10, 1'b0, 32'h0);
      step();
      in_valid = 1'b0;
      step();
      check_eq("hold_before_reset", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_valid", out_valid, 1'b0);
      check_eq("async_rst_target", out_target, 32'h0);
      check_eq("async_rst_in_ready", in_ready, 1'b1);
      for (int i = 0; i < N; i++) pred_check("async_rst_pred", i * 4, 1'b0);
      @(negedge clk);
      model_reset();
      drive_idle();
      rst_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
